bcd_reaction_counter: RTL

- Parametrised multi-digit BCD elapsed-time counter for the reaction timer. Successor to the fixed 4-digit counter.
- Counts 1 ms ticks while running and freezes the value on stop. Captures each stopped result and flags overflow.
- Sits between the game-control FSM, which drives cmd, and the 7-segment display mux, which reads bcd_out or result_out.

---
 rtl/bcd_reaction_counter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bcd_reaction_counter.sv
// Multi-digit BCD elapsed-time counter with RUN->STOP result capture and overflow flag.
// Best-result tracking is built only when BCD_REACTION_BEST_EN is defined.
module bcd_reaction_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b1,
  parameter int TICK_DIV = 1
) (
  input  logic                clk_1khz,
  input  logic                rst_n,
  input  logic [1:0]          cmd,
  input  logic                tick_en,
  input  logic                best_clr,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [4*DIGITS-1:0] result_out,
  output logic                result_valid,
  output logic                running,
  output logic                overflow,
  output logic [4*DIGITS-1:0] best_out
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_RUN   = 2'b10,
    S_STOP  = 2'b11
  } state_e;

  state_e         state_q, state_d, prev_q;
  logic [PW-1:0]  pre_q, pre_d;
  logic [W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]   result_q, result_d;
  logic           ovf_q, ovf_d;
  logic           rv_q, rv_d;
  logic           step;
  logic           run_to_stop;
  logic           carry;
  logic [3:0]     digit;

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      prev_q   <= S_IDLE;
      pre_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= state_q;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      rv_q     <= rv_d;
    end
  end

  // Decimal +1 with the carry rippling through all digits in one cycle.
  always_comb begin
    cnt_inc = '0;
    carry   = 1'b1;
    digit   = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = cnt_q[4*k +: 4];
      if (carry && (digit == 4'd9)) begin
        cnt_inc[4*k +: 4] = 4'd0;
      end else if (carry) begin
        cnt_inc[4*k +: 4] = digit + 4'd1;
        carry             = 1'b0;
      end else begin
        cnt_inc[4*k +: 4] = digit;
      end
    end
  end

  always_comb begin
    state_d     = state_e'(cmd);
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    step        = 1'b0;
    run_to_stop = (prev_q == S_RUN) && (state_q == S_STOP);
    result_d    = run_to_stop ? cnt_q : result_q;
    rv_d        = run_to_stop;

    case (state_q)
      S_IDLE, S_ARMED: begin
        pre_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      S_RUN: begin
        if (tick_en) begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            step  = 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (step) begin
      if (cnt_q == ALL_NINES) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? ALL_NINES : '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  assign bcd_out      = cnt_q;
  assign result_out   = result_q;
  assign result_valid = rv_q;
  assign running      = (state_q == S_RUN);
  assign overflow     = ovf_q;

`ifdef BCD_REACTION_BEST_EN
  logic [W-1:0] best_q, best_d;

  // Packed BCD with valid digits orders exactly like its decimal value, so a
  // plain magnitude compare is the MS-digit-first digit-wise compare.
  always_comb begin
    best_d = best_q;
    if (best_clr) begin
      best_d = ALL_NINES;
    end else if (run_to_stop && !ovf_q && (cnt_q < best_q)) begin
      best_d = cnt_q;
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= ALL_NINES;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_out = best_q;
`else
  logic unused_best_clr;
  assign unused_best_clr = best_clr;
  assign best_out        = ALL_NINES;
`endif

endmodule
